pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator: one shared period counter drives CHANNELS independent compare outputs. Each channel has its own duty cycle and polarity. Edge-aligned and center-aligned counting modes are supported. Software writes through a simple register port into shadow (pending) registers. Pending values become active only at a period boundary, so the outputs never glitch mid-period. The block sits behind the top-level IO wrapper, and its outputs drive LEDs or pins directly.

---
 rtl/pwm_multi.sv | 82 ++++++++
 tb/tb_pwm_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared edge/center counter and boundary-synchronised shadow registers
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                sync,
    output logic [WIDTH-1:0]    cnt_out
);
    localparam int CW = CHANNELS + 1;
    logic [WIDTH-1:0]    period_p, period_a, cnt_n;
    logic [WIDTH-1:0]    duty_p [CHANNELS];
    logic [WIDTH-1:0]    duty_a [CHANNELS];
    logic [CHANNELS-1:0] pol_p, pol_a, pol_n, raw_n;
    logic [CW-1:0]       ctrl_w;
    logic                mode_p, mode_a, dir, dir_n, run, bnd, load;
    if (WIDTH >= CW) begin : g_wide
        assign ctrl_w = wr_data[CW-1:0];
    end else begin : g_narrow
        assign ctrl_w = {{(CW - WIDTH){1'b0}}, wr_data};
    end
    // run is low on the first enabled cycle so the count always restarts from 0 there
    always_comb begin
        cnt_n = '0;
        if (run && period_a != '0)
            cnt_n = !mode_a ? (cnt_out >= period_a ? '0 : cnt_out + 1'b1)
                            : (dir ? cnt_out - 1'b1 : cnt_out + 1'b1);
        dir_n = (mode_a && cnt_n == period_a) ? 1'b1 : (cnt_n == '0) ? 1'b0 : dir;
        bnd   = en && cnt_n == '0;
        load  = bnd || !en;
        pol_n = load ? pol_p : pol_a;
        raw_n = '0;
        for (int c = 0; c < CHANNELS; c++)
            raw_n[c] = cnt_n < (load ? duty_p[c] : duty_a[c]);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_p <= '1;
            period_a <= '1;
            mode_p   <= 1'b0;
            mode_a   <= 1'b0;
            pol_p    <= '0;
            pol_a    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                duty_p[c] <= '0;
                duty_a[c] <= '0;
            end
            cnt_out  <= '0;
            dir      <= 1'b0;
            run      <= 1'b0;
            sync     <= 1'b0;
            pwm_out  <= '0;
        end else begin
            if (wr_en && wr_addr == ADDR_W'(0))
                period_p <= wr_data;
            if (wr_en && wr_addr == ADDR_W'(1))
                {pol_p, mode_p} <= ctrl_w;
            for (int c = 0; c < CHANNELS; c++)
                if (wr_en && wr_addr == ADDR_W'(c + 2))
                    duty_p[c] <= wr_data;
            if (load) begin
                period_a <= period_p;
                mode_a   <= mode_p;
                pol_a    <= pol_p;
                for (int c = 0; c < CHANNELS; c++)
                    duty_a[c] <= duty_p[c];
            end
            cnt_out <= en ? cnt_n : '0;
            dir     <= en && dir_n;
            run     <= en;
            sync    <= bnd;
            pwm_out <= en ? raw_n ^ pol_n : pol_n;
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed vector table plus hand-written shadow, enable and reset sequences
module tb_pwm_multi;
    logic       clk = 1'b0, resetn = 1'b0, en = 1'b0, wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] pwm_out;
    logic       sync;
    logic [7:0] cnt_out;
    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    pwm_multi dut (
        .clk(clk), .resetn(resetn), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pwm_out(pwm_out), .sync(sync), .cnt_out(cnt_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  period;
        logic [7:0]  ctrl;
        logic [31:0] duty;
        int          k;
        logic [7:0]  cnt;
        logic        sy;
        logic [3:0]  pwm;
    } vec_t;
    vec_t v[17];

    initial begin
        // duty packs {d3,d2,d1,d0}; k = cycles after the first enabled cycle
        v[0]  = '{8'd9,   8'h00, {8'd9, 8'd10, 8'd0, 8'd3}, 0,   8'd0,   1'b1, 4'b1101};
        v[1]  = '{8'd9,   8'h00, {8'd9, 8'd10, 8'd0, 8'd3}, 2,   8'd2,   1'b0, 4'b1101};
        v[2]  = '{8'd9,   8'h00, {8'd9, 8'd10, 8'd0, 8'd3}, 3,   8'd3,   1'b0, 4'b1100};
        v[3]  = '{8'd9,   8'h00, {8'd9, 8'd10, 8'd0, 8'd3}, 9,   8'd9,   1'b0, 4'b0100};
        v[4]  = '{8'd9,   8'h00, {8'd9, 8'd10, 8'd0, 8'd3}, 10,  8'd0,   1'b1, 4'b1101};
        v[5]  = '{8'd4,   8'h01, {8'd5, 8'd4,  8'd2, 8'd1}, 0,   8'd0,   1'b1, 4'b1111};
        v[6]  = '{8'd4,   8'h01, {8'd5, 8'd4,  8'd2, 8'd1}, 1,   8'd1,   1'b0, 4'b1110};
        v[7]  = '{8'd4,   8'h01, {8'd5, 8'd4,  8'd2, 8'd1}, 4,   8'd4,   1'b0, 4'b1000};
        v[8]  = '{8'd4,   8'h01, {8'd5, 8'd4,  8'd2, 8'd1}, 5,   8'd3,   1'b0, 4'b1100};
        v[9]  = '{8'd4,   8'h01, {8'd5, 8'd4,  8'd2, 8'd1}, 7,   8'd1,   1'b0, 4'b1110};
        v[10] = '{8'd4,   8'h01, {8'd5, 8'd4,  8'd2, 8'd1}, 8,   8'd0,   1'b1, 4'b1111};
        v[11] = '{8'd9,   8'h1E, {8'd9, 8'd10, 8'd0, 8'd3}, 0,   8'd0,   1'b1, 4'b0010};
        v[12] = '{8'd9,   8'h1E, {8'd9, 8'd10, 8'd0, 8'd3}, 3,   8'd3,   1'b0, 4'b0011};
        v[13] = '{8'd0,   8'h00, {8'd0, 8'd2,  8'd1, 8'd0}, 5,   8'd0,   1'b1, 4'b0110};
        v[14] = '{8'd200, 8'h00, {8'd0, 8'd0,  8'd0, 8'd255}, 200, 8'd200, 1'b0, 4'b0001};
        v[15] = '{8'd1,   8'h01, {8'd0, 8'd0,  8'd0, 8'd1}, 1,   8'd1,   1'b0, 4'b0000};
        v[16] = '{8'd1,   8'h01, {8'd0, 8'd0,  8'd0, 8'd1}, 2,   8'd0,   1'b1, 4'b0001};

        tick(2);
        chk("reset cnt", cnt_out, 0);
        chk("reset pwm", pwm_out, 0);
        chk("reset sync", sync, 0);
        @(negedge clk) resetn = 1'b1;
        tick(1);

        foreach (v[i]) begin
            en = 1'b0;
            wr(3'd0, v[i].period);
            wr(3'd1, v[i].ctrl);
            for (int c = 0; c < 4; c++) wr(3'(c + 2), v[i].duty[8*c +: 8]);
            en = 1'b1;
            tick(v[i].k + 1);
            chk($sformatf("vec%0d cnt", i), cnt_out, v[i].cnt);
            chk($sformatf("vec%0d sync", i), sync, v[i].sy);
            chk($sformatf("vec%0d pwm", i), pwm_out, v[i].pwm);
        end

        // shadow update: mid-period write waits for the boundary
        en = 1'b0;
        wr(3'd0, 8'd9);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'd3);
        en = 1'b1;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("edge cnt k%0d", k), cnt_out, k);
            chk($sformatf("edge pwm0 k%0d", k), pwm_out[0], k < 3);
            chk($sformatf("edge sync k%0d", k), sync, k == 0);
            tick(1);
        end
        tick(5);
        chk("shadow at cnt5", cnt_out, 5);
        wr(3'd2, 8'd8);
        chk("shadow cnt6 pwm0", pwm_out[0], 0);
        tick(3);
        chk("shadow cnt9 pwm0", pwm_out[0], 0);
        tick(1);
        chk("shadow new period sync", sync, 1);
        chk("shadow cnt0 pwm0", pwm_out[0], 1);
        tick(7);
        chk("shadow cnt7 pwm0", pwm_out[0], 1);
        tick(1);
        chk("shadow cnt8 pwm0", pwm_out[0], 0);
        tick(1);
        chk("boundary pre cnt", cnt_out, 9);
        wr(3'd2, 8'd2);
        chk("boundary write cnt", cnt_out, 0);
        tick(7);
        chk("boundary old duty cnt7", pwm_out[0], 1);
        tick(3);
        chk("boundary next cnt0 pwm0", pwm_out[0], 1);
        tick(2);
        chk("boundary next cnt2 pwm0", pwm_out[0], 0);

        // enable low: inactive level, immediate writes, sync on first enabled cycle
        en = 1'b0;
        wr(3'd1, 8'h08);
        chk("en0 pwm2 pre", pwm_out[2], 0);
        chk("en0 cnt", cnt_out, 0);
        chk("en0 sync", sync, 0);
        tick(1);
        chk("en0 pwm2 pol", pwm_out[2], 1);
        wr(3'd4, 8'd3);
        en = 1'b1;
        tick(1);
        chk("en1 sync", sync, 1);
        chk("en1 cnt", cnt_out, 0);
        chk("en1 pwm2", pwm_out[2], 0);
        tick(3);
        chk("en1 cnt3 pwm2", pwm_out[2], 1);

        // asynchronous reset mid-period
        en = 1'b0;
        wr(3'd0, 8'd9);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'd9);
        wr(3'd3, 8'd0);
        wr(3'd4, 8'd0);
        wr(3'd5, 8'd0);
        en = 1'b1;
        tick(7);
        chk("pre-reset cnt", cnt_out, 6);
        chk("pre-reset pwm", pwm_out, 4'b0001);
        resetn = 1'b0;
        #1;
        chk("async reset cnt", cnt_out, 0);
        chk("async reset pwm", pwm_out, 0);
        chk("async reset sync", sync, 0);
        @(negedge clk) resetn = 1'b1;
        tick(1);
        chk("post-reset sync", sync, 1);
        chk("post-reset pwm", pwm_out, 0);
        tick(255);
        chk("post-reset cnt255", cnt_out, 255);
        chk("post-reset sync255", sync, 0);
        chk("post-reset pwm255", pwm_out, 0);
        tick(1);
        chk("post-reset wrap cnt", cnt_out, 0);
        chk("post-reset wrap sync", sync, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
